// File: rtl/mem_bus_arbiter_pkg.sv
// Purpose: shared encodings for the IF/MEM memory bus arbiter (bus commands, FSM states, bus request word).
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mem_bus_arbiter_pkg;

    // Command encoding shared by the pipeline side (mem_cmd) and the memory side (bus_cmd).
    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_IF  = 2'd1,
        ST_BUSY_MEM = 2'd2
    } arb_state_e;

    // Everything the arbiter holds stable towards memory while a transaction is open.
    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    function automatic logic is_req(input logic [1:0] cmd);
        return cmd != BUS_NONE;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Purpose: cycle counter for an open bus transaction; flags when the transaction has run out of time.
// Latency: expired_o is a registered compare, high in the TIMEOUT-th enabled cycle after clear.
// Backpressure: none; the counter holds at its last value instead of wrapping.
//
// Ports: clk/rst (sync, active-high), clr_i (restart at 0), en_i (count this cycle),
//        expired_o (count has reached TIMEOUT-1).
module mem_bus_arbiter_bus_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one single-port memory bus between instruction fetch (IF) and data access (MEM); MEM has priority.
// Latency: request seen in cycle N -> bus command from N+1 -> requester ack at earliest N+2 (3 cycles back-to-back).
// Backpressure: requesters hold their request and see stall_if/stall_mem until their one-cycle ack.
//
// Ports: clk, rst (sync, active-high)
//        IF side : if_req, if_addr -> if_ack, if_rdata, stall_if
//        MEM side: mem_cmd, mem_addr, mem_wdata -> mem_ack, mem_rdata, stall_mem
//        memory  : bus_cmd, bus_addr, bus_wdata (registered) ; bus_rdata, bus_ack in ; bus_err out
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT        = 64,
    parameter int MAX_MEM_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic [1:0]  mem_cmd,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic [1:0]  bus_cmd,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err
);

    localparam int SW = $clog2(MAX_MEM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MEM_STREAK);

    arb_state_e    state_q, state_d;
    bus_req_t      bus_q, bus_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          if_ack_q, if_ack_d;
    logic          mem_ack_q, mem_ack_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   mem_rdata_q, mem_rdata_d;
    logic          bus_err_q, bus_err_d;
    // Sticky: IF let go of its request at some point during the open fetch, so the
    // returning data belongs to a fetch the pipeline no longer wants.
    logic          if_drop_q, if_drop_d;

    logic          if_pend, mem_pend;
    logic          grant_if, grant_mem, if_quiet;
    logic          wd_clr, wd_expired;

    // A requester being acked this cycle is still holding its (now finished) request;
    // masking it prevents the same transaction from being issued twice.
    assign if_pend  = if_req && !if_ack_q;
    assign mem_pend = is_req(mem_cmd) && !mem_ack_q;

    mem_bus_arbiter_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wd_clr),
        .en_i      (state_q != ST_IDLE),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        streak_d    = streak_q;
        if_drop_d   = if_drop_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        bus_err_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        wd_clr      = 1'b0;
        grant_mem   = 1'b0;
        grant_if    = 1'b0;
        if_quiet    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // MEM wins contention until it has taken MAX_MEM_STREAK grants in a row past a waiting IF.
                grant_mem = mem_pend && (!if_pend || (streak_q != STREAK_MAX));
                grant_if  = if_pend && !grant_mem;
                if (grant_mem) begin
                    bus_d   = '{cmd: mem_cmd, addr: mem_addr, wdata: mem_wdata};
                    state_d = ST_BUSY_MEM;
                    wd_clr  = 1'b1;
                    if (if_pend) begin
                        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                end else if (grant_if) begin
                    bus_d     = '{cmd: BUS_LOAD, addr: if_addr, wdata: 32'h0};
                    state_d   = ST_BUSY_IF;
                    wd_clr    = 1'b1;
                    streak_d  = '0;
                    if_drop_d = 1'b0;
                end
            end

            ST_BUSY_IF: begin
                if (!if_req) begin
                    if_drop_d = 1'b1;
                end
                // bus_ack takes precedence over a timeout landing in the same cycle.
                if (bus_ack || wd_expired) begin
                    state_d   = ST_IDLE;
                    bus_d.cmd = BUS_NONE;
                    if_quiet  = if_drop_q || !if_req;
                    if (!if_quiet) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus_ack ? bus_rdata : 32'h0;
                        bus_err_d  = !bus_ack;
                    end
                end
            end

            ST_BUSY_MEM: begin
                if (bus_ack || wd_expired) begin
                    state_d     = ST_IDLE;
                    bus_d.cmd   = BUS_NONE;
                    mem_ack_d   = 1'b1;
                    mem_rdata_d = bus_ack ? bus_rdata : 32'h0;
                    bus_err_d   = !bus_ack;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bus_d.cmd = BUS_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus_q       <= '0;
            streak_q    <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
            bus_err_q   <= 1'b0;
            if_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            streak_q    <= streak_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
            if_drop_q   <= if_drop_d;
        end
    end

    assign bus_cmd   = bus_q.cmd;
    assign bus_addr  = bus_q.addr;
    assign bus_wdata = bus_q.wdata;
    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_err   = bus_err_q;
    assign stall_if  = if_req && !if_ack_q;
    assign stall_mem = is_req(mem_cmd) && !mem_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose: directed scenarios for mem_bus_arbiter with a scoreboard of expected bus issues and acks.
// Latency: stimulus and responder act 1 time unit after posedge; the monitor samples on negedge.
// Backpressure: a behavioural memory acks each bus command after a configurable number of busy cycles.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int TO  = 16;
    localparam int STK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic [1:0]  mem_cmd;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic [1:0]  bus_cmd;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    mem_bus_arbiter #(.TIMEOUT(TO), .MAX_MEM_STREAK(STK)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } ack_t;

    op_t  exp_iss[$];
    ack_t exp_ifack[$];
    ack_t exp_memack[$];
    op_t  mem_ops[$];

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    // Memory responder configuration.
    bit resp_en    = 1'b1;
    bit resp_never = 1'b0;
    int resp_lat   = 0;
    int busy_cnt   = 0;
    bit starve_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vec_cnt++;
        err_cnt++;
        $display("FAIL %s: event not expected / not seen (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_issue(input logic [1:0] c, input logic [31:0] a, input logic [31:0] w);
        op_t o;
        o.cmd = c; o.addr = a; o.wdata = w;
        exp_iss.push_back(o);
    endtask

    task automatic exp_ack(input bit is_if, input logic [31:0] d, input logic e);
        ack_t k;
        k.rdata = d; k.err = e;
        if (is_if) exp_ifack.push_back(k);
        else exp_memack.push_back(k);
    endtask

    // Behavioural memory: acks in busy cycle resp_lat (0 = the first cycle bus_cmd is valid).
    always @(posedge clk) begin
        #1;
        if (resp_en) begin
            if (rst || bus_cmd == BUS_NONE) begin
                busy_cnt  = 0;
                bus_ack   = 1'b0;
                bus_rdata = 32'hBAD0_BAD0;
            end else begin
                bus_ack   = !resp_never && (busy_cnt == resp_lat);
                bus_rdata = bus_ack ? mem_model(bus_addr) : 32'hBAD0_BAD0;
                busy_cnt  = busy_cnt + 1;
            end
        end
    end

    // Monitor: every new bus command and every ack is matched against the scoreboard.
    logic [1:0] prev_cmd = BUS_NONE;
    op_t  m_iss;
    ack_t m_ack;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_cmd != BUS_NONE && prev_cmd == BUS_NONE) begin
                if (exp_iss.size() == 0) fail_now("unexpected bus issue");
                else begin
                    m_iss = exp_iss.pop_front();
                    chk("issue bus_cmd", 32'(bus_cmd), 32'(m_iss.cmd));
                    chk("issue bus_addr", bus_addr, m_iss.addr);
                    chk("issue bus_wdata", bus_wdata, m_iss.wdata);
                end
            end
            if (if_ack) begin
                if (exp_ifack.size() == 0) fail_now("unexpected if_ack");
                else begin
                    m_ack = exp_ifack.pop_front();
                    chk("if_rdata", if_rdata, m_ack.rdata);
                    chk("if bus_err", 32'(bus_err), 32'(m_ack.err));
                end
            end
            if (mem_ack) begin
                if (exp_memack.size() == 0) fail_now("unexpected mem_ack");
                else begin
                    m_ack = exp_memack.pop_front();
                    chk("mem_rdata", mem_rdata, m_ack.rdata);
                    chk("mem bus_err", 32'(bus_err), 32'(m_ack.err));
                end
            end
            if (if_ack || mem_ack) chk("acks exclusive", 32'(if_ack & mem_ack), 32'h0);
            if (bus_err && !if_ack && !mem_ack) fail_now("bus_err without ack");
        end
        prev_cmd = bus_cmd;
    end

    // Generic driver: presents queued MEM ops in order and the current IF request, keeping
    // each request up through its ack cycle and retiring it on the following cycle.
    task automatic run(input int budget, input bit chk_stall);
        bit mem_adv = 0, if_done = 0, if_restore = 0;
        int k = 0;
        op_t o;
        if (mem_ops.size() > 0) begin
            o = mem_ops.pop_front();
            mem_cmd = o.cmd; mem_addr = o.addr; mem_wdata = o.wdata;
        end
        while ((mem_cmd != BUS_NONE || if_req || if_restore) && k < budget) begin
            tick();
            k++;
            if (chk_stall && if_req) chk("stall_if", 32'(stall_if), 32'(!if_ack));
            if (chk_stall && mem_cmd != BUS_NONE) chk("stall_mem", 32'(stall_mem), 32'(!mem_ack));
            if (mem_adv) begin
                mem_adv = 0;
                if (mem_ops.size() > 0) begin
                    o = mem_ops.pop_front();
                    mem_cmd = o.cmd; mem_addr = o.addr; mem_wdata = o.wdata;
                end else mem_cmd = BUS_NONE;
            end
            if (if_done) begin if_done = 0; if_req = 1'b0; end
            if (if_restore) begin if_restore = 0; if_req = 1'b1; end
            if (mem_ack) begin
                mem_adv = 1;
                // Starvation scenario: IF lets go during each MEM ack cycle so every
                // contended IDLE cycle sees a fresh MEM op and the streak counter decides.
                if (starve_mode && if_req) begin if_req = 1'b0; if_restore = 1; end
            end
            if (if_ack) if_done = 1;
        end
        if (mem_cmd != BUS_NONE || if_req) begin
            fail_now("run cycle budget expired");
            mem_cmd = BUS_NONE;
            if_req  = 1'b0;
        end
    endtask

    task automatic drain_check(input string name);
        repeat (3) tick();
        chk({name, " issue queue empty"}, 32'(exp_iss.size()), 32'h0);
        chk({name, " if_ack queue empty"}, 32'(exp_ifack.size()), 32'h0);
        chk({name, " mem_ack queue empty"}, 32'(exp_memack.size()), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit reached (cycle %0d)", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int c0;
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
        mem_cmd = BUS_NONE; mem_addr = 32'h0; mem_wdata = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        chk("reset bus_cmd", 32'(bus_cmd), 32'(BUS_NONE));
        chk("reset bus_addr", bus_addr, 32'h0);
        chk("reset bus_wdata", bus_wdata, 32'h0);
        chk("reset if_ack", 32'(if_ack), 32'h0);
        chk("reset mem_ack", 32'(mem_ack), 32'h0);
        chk("reset if_rdata", if_rdata, 32'h0);
        chk("reset mem_rdata", mem_rdata, 32'h0);
        chk("reset bus_err", 32'(bus_err), 32'h0);
        tick();

        // IF only: issue at N+1, ack at N+2, no re-issue at N+3
        resp_lat = 0;
        if_req = 1'b1; if_addr = 32'h100;
        exp_issue(BUS_LOAD, 32'h100, 32'h0);
        exp_ack(1, 32'h0000_0013, 1'b0);
        tick();
        chk("ifonly N+1 bus_cmd", 32'(bus_cmd), 32'(BUS_LOAD));
        chk("ifonly N+1 bus_addr", bus_addr, 32'h100);
        chk("ifonly N+1 stall_if", 32'(stall_if), 32'h1);
        tick();
        chk("ifonly N+2 if_ack", 32'(if_ack), 32'h1);
        chk("ifonly N+2 if_rdata", if_rdata, 32'h0000_0013);
        chk("ifonly N+2 stall_if", 32'(stall_if), 32'h0);
        tick();
        if_req = 1'b0;
        chk("ifonly N+3 no reissue", 32'(bus_cmd), 32'(BUS_NONE));
        drain_check("ifonly");

        // Contention: store goes first, then the fetch
        resp_lat = 1;
        if_req = 1'b1; if_addr = 32'h104;
        mem_ops.push_back('{cmd: BUS_STORE, addr: 32'h2000, wdata: 32'hDEAD_BEEF});
        exp_issue(BUS_STORE, 32'h2000, 32'hDEAD_BEEF);
        exp_issue(BUS_LOAD, 32'h104, 32'h0);
        exp_ack(0, mem_model(32'h2000), 1'b0);
        exp_ack(1, mem_model(32'h104), 1'b0);
        run(60, 1'b1);
        drain_check("contention");

        // Starvation guard: MEM x4, IF, MEM x2
        resp_lat = 0;
        starve_mode = 1'b1;
        if_req = 1'b1; if_addr = 32'h400;
        for (int i = 0; i < 6; i++) begin
            mem_ops.push_back('{cmd: BUS_LOAD, addr: 32'h3000 + 32'(4 * i), wdata: 32'h0});
        end
        for (int i = 0; i < 4; i++) exp_issue(BUS_LOAD, 32'h3000 + 32'(4 * i), 32'h0);
        exp_issue(BUS_LOAD, 32'h400, 32'h0);
        for (int i = 4; i < 6; i++) exp_issue(BUS_LOAD, 32'h3000 + 32'(4 * i), 32'h0);
        for (int i = 0; i < 6; i++) exp_ack(0, mem_model(32'h3000 + 32'(4 * i)), 1'b0);
        exp_ack(1, mem_model(32'h400), 1'b0);
        run(200, 1'b0);
        starve_mode = 1'b0;
        drain_check("starvation");

        // Timeout: memory never answers
        resp_never = 1'b1;
        mem_cmd = BUS_LOAD; mem_addr = 32'h5000; mem_wdata = 32'h0;
        exp_issue(BUS_LOAD, 32'h5000, 32'h0);
        exp_ack(0, 32'h0, 1'b1);
        tick();
        c0 = cyc;
        chk("timeout bus_cmd valid", 32'(bus_cmd), 32'(BUS_LOAD));
        for (int i = 0; i < TO + 4 && !mem_ack; i++) tick();
        chk("timeout mem_ack", 32'(mem_ack), 32'h1);
        chk("timeout latency", 32'(cyc - c0), 32'(TO));
        chk("timeout bus_err", 32'(bus_err), 32'h1);
        chk("timeout mem_rdata", mem_rdata, 32'h0);
        chk("timeout bus_cmd none", 32'(bus_cmd), 32'(BUS_NONE));
        tick();
        mem_cmd = BUS_NONE;
        resp_never = 1'b0;
        drain_check("timeout");

        // bus_ack in the very cycle the watchdog expires: ack wins, no error
        resp_lat = TO - 1;
        mem_ops.push_back('{cmd: BUS_LOAD, addr: 32'h5004, wdata: 32'h0});
        exp_issue(BUS_LOAD, 32'h5004, 32'h0);
        exp_ack(0, mem_model(32'h5004), 1'b0);
        run(TO + 10, 1'b0);
        drain_check("ack at timeout");

        // Redirect: fetch withdrawn, no if_ack, new fetch granted on the next IDLE cycle
        resp_lat = 3;
        if_req = 1'b1; if_addr = 32'h300;
        exp_issue(BUS_LOAD, 32'h300, 32'h0);
        tick();
        chk("redirect N+1 bus_cmd", 32'(bus_cmd), 32'(BUS_LOAD));
        if_req = 1'b0;
        tick();
        tick();
        if_req = 1'b1; if_addr = 32'h200;
        exp_issue(BUS_LOAD, 32'h200, 32'h0);
        exp_ack(1, mem_model(32'h200), 1'b0);
        tick();
        tick();
        chk("redirect suppressed if_ack", 32'(if_ack), 32'h0);
        chk("redirect stall_if", 32'(stall_if), 32'h1);
        tick();
        chk("redirect new bus_cmd", 32'(bus_cmd), 32'(BUS_LOAD));
        chk("redirect new bus_addr", bus_addr, 32'h200);
        run(30, 1'b1);
        drain_check("redirect");

        // Reset in the middle of a MEM transaction, then a stray bus_ack
        resp_en = 1'b0;
        bus_ack = 1'b0;
        mem_cmd = BUS_LOAD; mem_addr = 32'h6000; mem_wdata = 32'h0;
        exp_issue(BUS_LOAD, 32'h6000, 32'h0);
        tick();
        tick();
        chk("midrst busy bus_cmd", 32'(bus_cmd), 32'(BUS_LOAD));
        rst = 1'b1;
        mem_cmd = BUS_NONE;
        tick();
        rst = 1'b0;
        chk("midrst bus_cmd", 32'(bus_cmd), 32'(BUS_NONE));
        chk("midrst bus_addr", bus_addr, 32'h0);
        chk("midrst bus_wdata", bus_wdata, 32'h0);
        chk("midrst mem_ack", 32'(mem_ack), 32'h0);
        chk("midrst if_rdata", if_rdata, 32'h0);
        chk("midrst mem_rdata", mem_rdata, 32'h0);
        chk("midrst bus_err", 32'(bus_err), 32'h0);
        tick();
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        tick();
        bus_ack = 1'b0;
        chk("midrst stray ack no mem_ack", 32'(mem_ack), 32'h0);
        chk("midrst stray ack bus_cmd", 32'(bus_cmd), 32'(BUS_NONE));
        tick();
        chk("midrst stray ack mem_rdata", mem_rdata, 32'h0);
        resp_en = 1'b1;
        resp_lat = 0;
        if_req = 1'b1; if_addr = 32'h100;
        exp_issue(BUS_LOAD, 32'h100, 32'h0);
        exp_ack(1, 32'h0000_0013, 1'b0);
        tick();
        chk("post-reset grant from IDLE", 32'(bus_cmd), 32'(BUS_LOAD));
        run(10, 1'b1);
        drain_check("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
